// File: rtl/hw_accel_seq_pkg.sv
// Shared types and default parameter values for the accelerator frame sequencer.
package hw_accel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_XFER,
    ST_FRAME_END,
    ST_ABORT
  } seq_state_e;

  localparam int DEF_FRAME_WIDTH         = 640;
  localparam int DEF_FRAME_HEIGHT        = 480;
  localparam int DEF_DMA_TRANSFER_LENGTH = 1920;
  localparam int DEF_ARM_PULSE_CYCLES    = 4;
  localparam int DEF_SOFT_RST_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES      = 1048576;

endpackage

// File: rtl/hw_accel_seq_pulse_gen.sv
// Fixed-length pulse timer: counts cycles while enabled and flags the last one.
module hw_accel_seq_pulse_gen #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at LAST until the owner drops en_i, so the next pulse starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/hw_accel_frame_sequencer.sv
// Frame sequencer: arms DMA write transfers, counts frames, watches for stalls
// and length errors, and flushes the accelerator on abort.
module hw_accel_frame_sequencer
  import hw_accel_seq_pkg::*;
#(
  parameter int FRAME_WIDTH         = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT        = DEF_FRAME_HEIGHT,
  parameter int DMA_TRANSFER_LENGTH = DEF_DMA_TRANSFER_LENGTH,
  parameter int ARM_PULSE_CYCLES    = DEF_ARM_PULSE_CYCLES,
  parameter int SOFT_RST_CYCLES     = DEF_SOFT_RST_CYCLES,
  parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_abort,
  input  logic [7:0] cfg_num_frames,
  input  logic       dma_rvalid,
  input  logic       dma_rready,
  input  logic       dma_wvalid,
  input  logic       dma_wlast,
  output logic       dma_init_done,
  output logic       accel_soft_rst,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       err_timeout,
  output logic       err_len,
  output logic       irq
);

  localparam int XFERS_PER_FRAME = (FRAME_WIDTH * FRAME_HEIGHT) / DMA_TRANSFER_LENGTH;
  localparam int WORD_W = $clog2(DMA_TRANSFER_LENGTH + 1);
  localparam int XFER_W = $clog2(XFERS_PER_FRAME + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WORD_W-1:0] WORD_ONE  = WORD_W'(1);
  localparam logic [WORD_W-1:0] WORD_LEN  = WORD_W'(DMA_TRANSFER_LENGTH);
  localparam logic [XFER_W-1:0] XFER_ONE  = XFER_W'(1);
  localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(XFERS_PER_FRAME - 1);
  localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d, beats;
  logic [XFER_W-1:0] xfer_q, xfer_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              err_to_q, err_to_d, err_len_q, err_len_d;
  logic              err_to_prev_q, err_len_prev_q;
  logic              irq_q, irq_d;
  logic              activity, arm_done, abort_done;

  hw_accel_seq_pulse_gen #(.CYCLES(ARM_PULSE_CYCLES)) u_arm_pulse (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_ARM),
    .done_o (arm_done)
  );

  hw_accel_seq_pulse_gen #(.CYCLES(SOFT_RST_CYCLES)) u_abort_pulse (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_ABORT),
    .done_o (abort_done)
  );

  assign activity = dma_wvalid | (dma_rvalid & dma_rready);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    xfer_d    = xfer_q;
    fcnt_d    = fcnt_q;
    err_to_d  = err_to_q;
    err_len_d = err_len_q;
    beats     = word_q + (dma_wvalid ? WORD_ONE : '0);
    wd_d      = (state_q != ST_XFER || activity) ? '0 : wd_q + WD_ONE;
    irq_d     = (state_q == ST_FRAME_END) | (err_len_q & ~err_len_prev_q)
              | (err_to_q & ~err_to_prev_q);

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          fcnt_d    = '0;
          err_to_d  = 1'b0;
          err_len_d = 1'b0;
          word_d    = '0;
          xfer_d    = '0;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (cfg_abort)     state_d = ST_ABORT;
        else if (arm_done) state_d = ST_XFER;
      end
      ST_XFER: begin
        // Abort beats wlast, and wlast beats the watchdog.
        if (cfg_abort) begin
          state_d = ST_ABORT;
        end else if (dma_wlast) begin
          if (beats != WORD_LEN) err_len_d = 1'b1;
          word_d = '0;
          wd_d   = '0;
          if (xfer_q == XFER_LAST) begin
            xfer_d  = '0;
            state_d = ST_FRAME_END;
          end else begin
            xfer_d  = xfer_q + XFER_ONE;
            state_d = ST_ARM;
          end
        end else begin
          if (dma_wvalid) word_d = word_q + WORD_ONE;
          if (!activity && wd_q == WD_LAST) begin
            err_to_d = 1'b1;
            state_d  = ST_ABORT;
          end
        end
      end
      ST_FRAME_END: begin
        fcnt_d = fcnt_q + 8'd1;
        if (cfg_abort)                                           state_d = ST_ABORT;
        else if (cfg_num_frames != 8'd0 && fcnt_d == cfg_num_frames) state_d = ST_IDLE;
        else                                                     state_d = ST_ARM;
      end
      ST_ABORT: begin
        word_d = '0;
        xfer_d = '0;
        if (abort_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      word_q         <= '0;
      xfer_q         <= '0;
      wd_q           <= '0;
      fcnt_q         <= '0;
      err_to_q       <= 1'b0;
      err_len_q      <= 1'b0;
      err_to_prev_q  <= 1'b0;
      err_len_prev_q <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      xfer_q         <= xfer_d;
      wd_q           <= wd_d;
      fcnt_q         <= fcnt_d;
      err_to_q       <= err_to_d;
      err_len_q      <= err_len_d;
      err_to_prev_q  <= err_to_q;
      err_len_prev_q <= err_len_q;
      irq_q          <= irq_d;
    end
  end

  assign dma_init_done  = (state_q == ST_ARM);
  assign accel_soft_rst = (state_q == ST_ABORT);
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = (state_q == ST_FRAME_END);
  assign frame_count    = fcnt_q;
  assign err_timeout    = err_to_q;
  assign err_len        = err_len_q;
  assign irq            = irq_q;

endmodule
